// File: rtl/float_seq_unit_if.sv
// Request/response bundle between processor stage 2 and the float sequencer.
interface float_seq_unit_if #(
    parameter int TAGW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_op;
    logic [15:0]     in_a;
    logic [15:0]     in_b;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_res;
    logic [TAGW-1:0] out_tag;
    logic            out_err;

    modport master (output in_valid, in_op, in_a, in_b, in_tag, out_ready,
                    input  in_ready, out_valid, out_res, out_tag, out_err);
    modport slave  (input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
                    output in_ready, out_valid, out_res, out_tag, out_err);
endinterface

// File: rtl/float_seq_unit.sv
// Multi-cycle 16-bit float unit (1/8/7 format, bias 127): add/sub, shift-add
// multiply and int<->float conversions, one operation at a time.
module float_seq_unit #(
    parameter int TAGW      = 4,
    parameter int MUL_ITERS = 8
) (
    input  logic            clk,
    input  logic            reset,
    float_seq_unit_if.slave bus
);
    localparam logic [4:0] OP_ADDF = 5'h11;
    localparam logic [4:0] OP_FTOI = 5'h12;
    localparam logic [4:0] OP_ITOF = 5'h13;
    localparam logic [4:0] OP_MULF = 5'h14;
    localparam logic [4:0] OP_SUBF = 5'h16;
    localparam int         CNTW    = $clog2(MUL_ITERS + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_UNPACK, ST_ALIGN, ST_ADD, ST_MUL, ST_NORM, ST_PACK, ST_DONE
    } state_t;

    state_t             state_r;
    logic [4:0]         op_r;
    logic [15:0]        a_r, b_r, byp_val_r, prod_r, mcand_r, mag_r;
    logic [TAGW-1:0]    tag_r, out_tag_r;
    logic               sign_r, sub_r, byp_r;
    logic signed [9:0]  exp_r;
    logic [7:0]         big_man_r, small_man_r, diff_r, man_r;
    logic [CNTW-1:0]    cnt_r;
    logic               out_valid_r, out_err_r;
    logic [15:0]        out_res_r;

    logic [7:0]         ea_s, eb_s, ma_s, mb_s;
    logic               a_zero_s, b_zero_s, b_sign_s, a_big_s;
    logic [8:0]         sum9_s;
    logic [3:0]         lz_s, msb_s, fe_s;
    logic [6:0]         norm_man_s, itof_man_s;
    logic signed [9:0]  norm_exp_s;
    logic [15:0]        norm_res_s, pack_res_s, ftoi_mag_s;

    // Number of leading zeros in an 8-bit mantissa (8 when it is all zero).
    function automatic logic [3:0] lzc8(input logic [7:0] m);
        logic [3:0] n;
        n = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) n = 4'(7 - i);
            else      n = n;
        end
        return n;
    endfunction

    // Bit index of the highest set bit of a 16-bit magnitude.
    function automatic logic [3:0] msb16(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

    // Final packing with overflow saturation and underflow flush to zero.
    function automatic logic [15:0] pack_fp(input logic s, input logic signed [9:0] e,
                                            input logic [6:0] m);
        if (e > 10'sd254)    return {s, 8'hFE, 7'h7F};
        else if (e < 10'sd1) return 16'h0000;
        else                 return {s, e[7:0], m};
    endfunction

    // Operand fields and add/sub magnitude ordering seen from UNPACK.
    always_comb begin
        ea_s     = a_r[14:7];
        eb_s     = b_r[14:7];
        ma_s     = {1'b1, a_r[6:0]};
        mb_s     = {1'b1, b_r[6:0]};
        a_zero_s = (ea_s == 8'd0);
        b_zero_s = (eb_s == 8'd0);
        b_sign_s = b_r[15] ^ (op_r == OP_SUBF);
        a_big_s  = (a_r[14:0] >= b_r[14:0]);
        sum9_s   = sub_r ? ({1'b0, big_man_r} - {1'b0, small_man_r})
                         : ({1'b0, big_man_r} + {1'b0, small_man_r});
    end

    // Normalisation result for add/sub and multiply.
    always_comb begin
        lz_s       = lzc8(man_r);
        norm_man_s = 7'(man_r << lz_s);
        norm_exp_s = exp_r - $signed({6'd0, lz_s});
        if (byp_r) begin
            norm_res_s = byp_val_r;
        end else if (op_r == OP_MULF) begin
            if (prod_r[15]) norm_res_s = pack_fp(sign_r, exp_r + 10'sd1, prod_r[14:8]);
            else            norm_res_s = pack_fp(sign_r, exp_r, prod_r[13:7]);
        end else if (man_r == 8'd0) begin
            norm_res_s = 16'h0000;
        end else begin
            norm_res_s = pack_fp(sign_r, norm_exp_s, norm_man_s);
        end
    end

    // Conversion results; the FTOI shift is only meaningful once range checks pass.
    always_comb begin
        msb_s      = msb16(mag_r);
        itof_man_s = 7'({mag_r, 7'd0} >> msb_s);
        fe_s       = 4'(b_r[14:7] - 8'd127);
        ftoi_mag_s = 16'(({15'd0, 1'b1, b_r[6:0]} << fe_s) >> 5'd7);
        if (op_r == OP_ITOF) begin
            if (mag_r == 16'd0) pack_res_s = 16'h0000;
            else                pack_res_s = {sign_r, 8'd127 + {4'd0, msb_s}, itof_man_s};
        end else if (b_r[14:7] < 8'd127) begin
            pack_res_s = 16'h0000;
        end else if (b_r[14:7] > 8'd141) begin
            pack_res_s = b_r[15] ? 16'h8000 : 16'h7FFF;
        end else begin
            pack_res_s = b_r[15] ? (16'd0 - ftoi_mag_s) : ftoi_mag_s;
        end
    end

    // Sequencer: handshake, state walk and all datapath/output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            op_r        <= 5'd0;
            a_r         <= 16'd0;
            b_r         <= 16'd0;
            tag_r       <= '0;
            sign_r      <= 1'b0;
            sub_r       <= 1'b0;
            byp_r       <= 1'b0;
            byp_val_r   <= 16'd0;
            exp_r       <= 10'sd0;
            big_man_r   <= 8'd0;
            small_man_r <= 8'd0;
            diff_r      <= 8'd0;
            man_r       <= 8'd0;
            prod_r      <= 16'd0;
            mcand_r     <= 16'd0;
            mag_r       <= 16'd0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            out_res_r   <= 16'd0;
            out_tag_r   <= '0;
            out_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_r    <= bus.in_op;
                        a_r     <= bus.in_a;
                        b_r     <= bus.in_b;
                        tag_r   <= bus.in_tag;
                        state_r <= ST_UNPACK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_UNPACK: begin
                    case (op_r)
                        OP_ADDF, OP_SUBF: begin
                            byp_r <= a_zero_s | b_zero_s;
                            if (a_zero_s && b_zero_s) byp_val_r <= 16'h0000;
                            else if (a_zero_s)        byp_val_r <= {b_sign_s, b_r[14:0]};
                            else                      byp_val_r <= a_r;
                            sub_r <= a_r[15] ^ b_sign_s;
                            if (a_big_s) begin
                                sign_r      <= a_r[15];
                                exp_r       <= {2'b00, ea_s};
                                big_man_r   <= ma_s;
                                small_man_r <= mb_s;
                                diff_r      <= ea_s - eb_s;
                            end else begin
                                sign_r      <= b_sign_s;
                                exp_r       <= {2'b00, eb_s};
                                big_man_r   <= mb_s;
                                small_man_r <= ma_s;
                                diff_r      <= eb_s - ea_s;
                            end
                            state_r <= ST_ALIGN;
                        end
                        OP_MULF: begin
                            byp_r       <= a_zero_s | b_zero_s;
                            byp_val_r   <= 16'h0000;
                            sign_r      <= a_r[15] ^ b_r[15];
                            exp_r       <= $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - 10'sd127;
                            mcand_r     <= {8'd0, ma_s};
                            small_man_r <= mb_s;
                            prod_r      <= 16'd0;
                            cnt_r       <= '0;
                            state_r     <= ST_MUL;
                        end
                        OP_ITOF: begin
                            sign_r  <= b_r[15];
                            mag_r   <= b_r[15] ? (16'd0 - b_r) : b_r;
                            state_r <= ST_PACK;
                        end
                        OP_FTOI: begin
                            state_r <= ST_PACK;
                        end
                        default: begin
                            out_res_r   <= 16'h0000;
                            out_err_r   <= 1'b1;
                            out_tag_r   <= tag_r;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end
                    endcase
                end
                ST_ALIGN: begin
                    small_man_r <= (diff_r > 8'd8) ? 8'd0 : (small_man_r >> diff_r);
                    state_r     <= ST_ADD;
                end
                ST_ADD: begin
                    // A carry out of the 8-bit sum renormalises by one to the right.
                    if (sum9_s[8]) begin
                        man_r <= sum9_s[8:1];
                        exp_r <= exp_r + 10'sd1;
                    end else begin
                        man_r <= sum9_s[7:0];
                    end
                    state_r <= ST_NORM;
                end
                ST_MUL: begin
                    if (small_man_r[0]) prod_r <= prod_r + mcand_r;
                    else                prod_r <= prod_r;
                    mcand_r     <= mcand_r << 1;
                    small_man_r <= small_man_r >> 1;
                    cnt_r       <= cnt_r + 1'b1;
                    if (cnt_r == CNTW'(MUL_ITERS - 1)) state_r <= ST_NORM;
                    else                               state_r <= ST_MUL;
                end
                ST_NORM: begin
                    out_res_r   <= norm_res_s;
                    out_err_r   <= 1'b0;
                    out_tag_r   <= tag_r;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_PACK: begin
                    out_res_r   <= pack_res_s;
                    out_err_r   <= 1'b0;
                    out_tag_r   <= tag_r;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_res   = out_res_r;
    assign bus.out_tag   = out_tag_r;
    assign bus.out_err   = out_err_r;
endmodule

// File: tb/tb_float_seq_unit.sv
// Directed bench for float_seq_unit: the driver queues expected results, a
// monitor compares each new result (value, tag, error, latency) against the queue.
module tb_float_seq_unit;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   cyc;
    logic prev_valid;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  tag;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    float_seq_unit_if #(.TAGW(4)) bus ();

    float_seq_unit #(.TAGW(4), .MUL_ITERS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: compare the first cycle of every presented result with the queue head.
    always @(negedge clk) begin
        if (bus.out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got res 0x%0h tag %0d, expected no result",
                         bus.out_res, bus.out_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_res", 32'(bus.out_res), 32'(e.res));
                check("out_tag", 32'(bus.out_tag), 32'(e.tag));
                check("out_err", 32'(bus.out_err), 32'(e.err));
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
        prev_valid <= bus.out_valid;
    end

    // Present one request once the unit is idle; optionally queue its expectation.
    task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] tag, input logic [15:0] res, input logic err,
                         input int lat, input bit push);
        int   n;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: in_ready stayed 0, expected 1");
        end else begin
            bus.in_valid = 1'b1;
            bus.in_op    = op;
            bus.in_a     = a;
            bus.in_b     = b;
            bus.in_tag   = tag;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_op    = 5'h00;
            if (push) begin
                e.res = res; e.tag = tag; e.err = err; e.lat = lat; e.acc = cyc;
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        int n;
        tests = 0; fails = 0; cyc = 0; prev_valid = 1'b0;
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 5'h00; bus.in_a = 16'h0000;
        bus.in_b = 16'h0000; bus.in_tag = 4'h0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_res",   32'(bus.out_res),   32'd0);
        check("rst_out_tag",   32'(bus.out_tag),   32'd0);
        check("rst_out_err",   32'(bus.out_err),   32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        reset = 1'b1;

        // ADDF with the consumer stalling for three cycles.
        bus.out_ready = 1'b0;
        issue(5'h11, 16'h3F80, 16'h4000, 4'h5, 16'h4040, 1'b0, 4, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            check("hold_valid",    32'(bus.out_valid), 32'd1);
            check("hold_res",      32'(bus.out_res),   32'h4040);
            check("hold_tag",      32'(bus.out_tag),   32'h5);
            check("hold_in_ready", 32'(bus.in_ready),  32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;

        issue(5'h16, 16'h3F80, 16'h3F80, 4'h1, 16'h0000, 1'b0, 4, 1'b1);
        issue(5'h16, 16'h3F80, 16'h4040, 4'h2, 16'hC000, 1'b0, 4, 1'b1);
        issue(5'h16, 16'h3F90, 16'h3F80, 4'h8, 16'h3E00, 1'b0, 4, 1'b1);
        issue(5'h11, 16'h0000, 16'h4040, 4'h9, 16'h4040, 1'b0, 4, 1'b1);
        issue(5'h16, 16'h0000, 16'h4040, 4'hA, 16'hC040, 1'b0, 4, 1'b1);
        issue(5'h11, 16'h4000, 16'h3800, 4'hB, 16'h4000, 1'b0, 4, 1'b1);
        issue(5'h14, 16'h3FC0, 16'h4000, 4'h3, 16'h4040, 1'b0, 10, 1'b1);
        issue(5'h14, 16'h7F00, 16'h7F00, 4'h4, 16'h7F7F, 1'b0, 10, 1'b1);
        issue(5'h14, 16'h0000, 16'h4040, 4'h6, 16'h0000, 1'b0, 10, 1'b1);
        issue(5'h14, 16'h3FC0, 16'h3FC0, 4'hC, 16'h4010, 1'b0, 10, 1'b1);
        issue(5'h13, 16'h1234, 16'h0005, 4'h1, 16'h40A0, 1'b0, 2, 1'b1);
        issue(5'h13, 16'h1234, 16'hFFFF, 4'h2, 16'hBF80, 1'b0, 2, 1'b1);
        issue(5'h13, 16'h0000, 16'h8000, 4'h3, 16'hC700, 1'b0, 2, 1'b1);
        issue(5'h12, 16'h1234, 16'hC040, 4'h4, 16'hFFFD, 1'b0, 2, 1'b1);
        issue(5'h12, 16'h0000, 16'h3F00, 4'h5, 16'h0000, 1'b0, 2, 1'b1);
        issue(5'h12, 16'h0000, 16'h4780, 4'h6, 16'h7FFF, 1'b0, 2, 1'b1);
        issue(5'h12, 16'h0000, 16'hC780, 4'h7, 16'h8000, 1'b0, 2, 1'b1);
        issue(5'h15, 16'h3F80, 16'h3F80, 4'hD, 16'h0000, 1'b1, 1, 1'b1);
        issue(5'h11, 16'h4000, 16'h4000, 4'h7, 16'h4080, 1'b0, 4, 1'b1);

        // Abort a multiply mid-way; no result may appear afterwards.
        issue(5'h14, 16'h4040, 16'h4040, 4'hE, 16'h0000, 1'b0, 10, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (12) @(negedge clk);
        issue(5'h14, 16'h4040, 16'h4000, 4'hF, 16'h40C0, 1'b0, 10, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pending_results", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/float_seq_unit.md
Name: float_seq_unit

Overview:
- Multi-cycle floating-point execution unit consumed by the processor's stage 2 (ALU/writeback) in place of the free-running per-op float modules.
- Stage 2 hands over an opcode and operands via a valid/ready handshake, then stalls until the unit presents a registered result with a writeback tag.
- Float format is 16-bit: sign[15], exp[14:7] with bias 127, man[6:0] with an implicit leading 1.
- 16'h0000 is the only zero encoding; any exp==0 input is treated as zero. There is no inf, NaN or denormal support.

Parameters:
- TAGW, 4, width of the passthrough tag (destination register number).
- MUL_ITERS, 8, number of shift-add iterations for the 8x8 mantissa multiply.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit idle and able to accept.
- in_op  in  5  opcode: 0x11 ADDF, 0x12 FTOI, 0x13 ITOF, 0x14 MULF, 0x16 SUBF.
- in_a  in  16  rd operand.
- in_b  in  16  rn operand; the sole operand for FTOI and ITOF.
- in_tag  in  TAGW  destination tag, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_res  out  16  result.
- out_tag  out  TAGW  tag captured at accept.
- out_err  out  1  unsupported opcode.

Behaviour:
- Reset: sampled on the clk edge while reset==0. Forces IDLE with out_valid=0, out_res=0, out_tag=0, out_err=0. Aborts any operation in flight with no output. The first edge after release sees IDLE.
- in_ready = (state==IDLE), combinational. Accept occurs on an edge with in_valid & in_ready, and captures in_op, in_a, in_b and in_tag. Inputs are ignored outside IDLE.
- States: IDLE, UNPACK, ALIGN, ADD, MUL, NORM, PACK, DONE.
  - ADDF/SUBF: UNPACK -> ALIGN -> ADD -> NORM -> DONE.
  - MULF: UNPACK -> MUL (MUL_ITERS cycles) -> NORM -> DONE.
  - ITOF: UNPACK -> PACK -> DONE.
  - FTOI: UNPACK -> PACK -> DONE.
  - Any other opcode: DONE directly, with out_res=0 and out_err=1.
- Latency from the accepting edge to the edge that raises out_valid: ADDF/SUBF 4, MULF 10, ITOF 2, FTOI 2, unsupported op 1.
- DONE: out_valid=1 and out_res/out_tag/out_err hold stable until an edge with out_ready=1, which returns the unit to IDLE and clears out_valid.
  - in_ready is 0 throughout DONE, so back-to-back accepts are at least one cycle apart.
  - out_ready is ignored outside DONE.
- ADDF/SUBF:
  - SUBF is computed as a + (-b).
  - A zero operand passes the other operand through; for SUBF with a==0 the result is -b.
  - Alignment right-shifts the smaller 8-bit mantissa (implicit 1 included) by the exponent difference; a difference above 8 yields 0.
  - Same signs: add, and on carry-out increment the exponent and shift right by 1.
  - Different signs: subtract the smaller magnitude from the larger, taking the sign of the larger magnitude. Equal magnitudes give 16'h0000.
  - NORM left-shifts by the leading-zero count (single cycle) and decrements the exponent by the same amount.
- MULF:
  - Either operand zero gives 16'h0000.
  - sign = a^b.
  - Exponent is ea+eb-127, computed at 10 bits.
  - Mantissa product is 16 bits, one shift-add bit per MUL cycle. If product[15] is set, exponent +1 and mantissa = product[14:8]; otherwise mantissa = product[13:7].
- Rounding is truncation everywhere.
- Exponent handling after NORM:
  - Exponent > 254 saturates to {sign, 8'hFE, 7'h7F}.
  - Exponent < 1 gives 16'h0000.
- ITOF: two's-complement in_b to sign-magnitude. 0 gives 0. Exponent = 127 + msb_index; mantissa = the 7 bits below the msb, truncated.
- FTOI:
  - exp < 127 gives 0.
  - exp-127 > 14 saturates to 0x7FFF (positive) or 0x8000 (negative).
  - Otherwise shift {1,man} by exp-127-7, truncating toward zero, then negate if sign is set.
- Arithmetic uses internal widths sufficient to avoid silent wrap: 9-bit mantissa sum, 10-bit signed exponent.

Test Plan:
- ADDF 0x3F80 + 0x4000 -> out_res 0x4040 with out_valid exactly 4 edges after accept; tag 0x5 returned. With out_ready held low for 3 cycles, result stays stable and in_ready stays 0.
- SUBF 0x3F80 - 0x3F80 -> 0x0000. SUBF 0x3F80 - 0x4040 -> 0xC000.
- MULF 0x3FC0 * 0x4000 -> 0x4040 at latency 10. MULF 0x7F00 * 0x7F00 -> 0x7F7F (saturate). MULF 0x0000 * 0x4040 -> 0x0000.
- ITOF 0x0005 -> 0x40A0. ITOF 0xFFFF -> 0xBF80. FTOI 0xC040 -> 0xFFFD. FTOI 0x3F00 -> 0x0000. FTOI 0x4780 -> 0x7FFF. All at latency 2.
- in_op 0x15 -> out_err=1, out_res=0 at latency 1. The next accept ADDF gives out_err=0.
- reset driven low during MUL cycle 5 -> no out_valid; in_ready=1 on the edge after release. A fresh MULF then completes correctly.
